alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Decode/issue stage that drives the existing 32-bit ALU: it produces alu_op, alu_a and alu_b from 32-bit MIPS-subset instructions.
- Holds one instruction in a registered ID/EX stage with valid/ready handshakes on both sides.
- Takes the ALU zero flag back to resolve BEQ/BNE, then pulses a branch redirect and discards wrong-path beats.
- Sits between instruction fetch/register-file read and the ALU.

Parameters:
FLUSH_CYCLES, 1, number of input beats discarded after a taken branch (0 = none).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept or discard a beat
instr  input  32  instruction word
pc  input  32  instruction address
rs_data  input  32  register file value for instr[25:21]
rt_data  input  32  register file value for instr[20:16]
out_valid  output  1  stage holds a decoded instruction
out_ready  input  1  downstream consumes stage this cycle
alu_op  output  4  ALU operation code
alu_a  output  32  ALU operand A
alu_b  output  32  ALU operand B
zero  input  1  ALU zero flag for current alu_a/alu_b/alu_op
dest_reg  output  5  write-back register
reg_write  output  1  write-back enable
mem_read  output  1  LW
mem_write  output  1  SW
store_data  output  32  rt_data for SW
illegal  output  1  unsupported encoding
branch_taken  output  1  one-cycle redirect pulse
branch_target  output  32  redirect address, valid with branch_taken

Behaviour:
- Reset: all outputs and stage registers 0; flush counter 0; in_ready=1 combinationally after reset.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - A beat is accepted when in_valid && in_ready.
  - Accepted non-discarded beat: stage loads next edge, out_valid=1 (latency 1).
  - Stage held stable while out_valid && !out_ready.
  - Consume without accept: out_valid clears.
  - Consume and accept in the same cycle: full throughput, one per cycle.
- Decode, R-type (opcode 0x00): funct 0x20 add→0010, 0x22 sub→0110, 0x24 and→0000, 0x25 or→0001, 0x27 nor→1100, 0x2A slt→0111. Operands a=rs_data, b=rt_data; dest=rd; reg_write=1.
- Decode, I-type (dest=rt):
  - addi 0x08 → 0010, sign-extended imm.
  - slti 0x0A → 0111, sign-extended imm.
  - andi 0x0C → 0000, zero-extended imm.
  - ori 0x0D → 0001, zero-extended imm.
  - lw 0x23 → 0010, sign-extended imm, mem_read=1, reg_write=1.
  - sw 0x2B → 0010, sign-extended imm, mem_write=1, reg_write=0.
- Decode, branches: beq 0x04 and bne 0x05 → 0110, a=rs_data, b=rt_data, reg_write=0. Stage stores target = pc+4+(sext(imm)<<2), modulo 2^32.
- Illegal: any other opcode/funct gives illegal=1, alu_op=0000, reg_write/mem_read/mem_write=0. The beat still passes through the handshake.
- Branch resolution:
  - Fires in the cycle out_valid && out_ready && stage is a branch.
  - taken = beq ? zero : !zero.
  - If taken: next edge branch_taken=1 for exactly one cycle and branch_target = stored target. The flush counter loads FLUSH_CYCLES.
  - A beat accepted in the firing cycle counts as the first discarded beat: it is not loaded, and the counter loads FLUSH_CYCLES-1 instead.
  - The zero→stage-load path is combinational.
- Flush:
  - While counter>0, in_ready=1, stage is not written, and each accepted beat decrements the counter.
  - Counter does not decrement without in_valid.
  - A stage already consumed stays empty during flush.
- Back-to-back taken branches cannot occur, since the wrong-path beat is discarded.
- Async reset mid-flush or mid-stall: everything clears immediately; no pulse is emitted.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR.
  - Opcode constants: OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE.
  - Funct constants.
- One combinational sub-module, alu_decode: instr → alu_op, immediate-extension select, dest select, control flags, illegal.
- alu_issue_ctrl holds the stage register, handshake, branch and flush logic.

Test Plan:
- add $3,$1,$2 (0x00221820), pc=0x0, rs_data=5, rt_data=7, out_ready=1 → next cycle out_valid=1, alu_op=0010, alu_a=5, alu_b=7, dest_reg=3, reg_write=1.
- addi 0x2022FFFF → alu_b=0xFFFFFFFF, dest_reg=2. ori 0x3422FFFF → alu_b=0x0000FFFF, alu_op=0001.
- beq 0x10220003 at pc=0x100, zero=1 on consume, next beat offered the same cycle → branch_taken pulse 1 cycle later with branch_target=0x110. That beat is discarded; the following beat issues normally.
- bne 0x14220003 with zero=1 → no branch_taken, no discard. Repeat with zero=0 → taken, target=0x110.
- out_ready=0 for 3 cycles with stage full → in_ready=0 and outputs stable; release → one beat per cycle resumes.
- instr 0x00000003 → illegal=1, reg_write=0, alu_op=0000. Assert rst_n low during the flush window → all outputs 0 immediately, and the counter is cleared after release.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue stage: ALU op codes, MIPS-subset opcode/funct
// values and the decoded control bundle.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_SEXT = 2'd1,
        IMM_ZEXT = 2'd2
    } imm_sel_e;

    typedef struct packed {
        logic [3:0] alu_op;
        imm_sel_e   imm_sel;
        logic       dest_rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       is_beq;
        logic       is_bne;
        logic       illegal;
    } dec_t;

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Pure combinational opcode/funct decoder feeding the issue stage register.
module alu_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec         = '0;
        dec.imm_sel = IMM_NONE;
        case (opcode)
            OP_RTYPE: begin
                dec.dest_rd   = 1'b1;
                dec.reg_write = 1'b1;
                case (funct)
                    F_ADD:   dec.alu_op = ALU_ADD;
                    F_SUB:   dec.alu_op = ALU_SUB;
                    F_AND:   dec.alu_op = ALU_AND;
                    F_OR:    dec.alu_op = ALU_OR;
                    F_NOR:   dec.alu_op = ALU_NOR;
                    F_SLT:   dec.alu_op = ALU_SLT;
                    default: begin
                        dec.illegal   = 1'b1;
                        dec.reg_write = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                dec.alu_op    = ALU_ADD;
                dec.imm_sel   = IMM_SEXT;
                dec.reg_write = 1'b1;
            end
            OP_SLTI: begin
                dec.alu_op    = ALU_SLT;
                dec.imm_sel   = IMM_SEXT;
                dec.reg_write = 1'b1;
            end
            OP_ANDI: begin
                dec.alu_op    = ALU_AND;
                dec.imm_sel   = IMM_ZEXT;
                dec.reg_write = 1'b1;
            end
            OP_ORI: begin
                dec.alu_op    = ALU_OR;
                dec.imm_sel   = IMM_ZEXT;
                dec.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.alu_op    = ALU_ADD;
                dec.imm_sel   = IMM_SEXT;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
            end
            OP_SW: begin
                dec.alu_op    = ALU_ADD;
                dec.imm_sel   = IMM_SEXT;
                dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_op = ALU_SUB;
                dec.is_beq = 1'b1;
            end
            OP_BNE: begin
                dec.alu_op = ALU_SUB;
                dec.is_bne = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ID/EX issue stage: decodes one instruction into ALU controls, resolves BEQ/BNE
// from the ALU zero flag and discards wrong-path beats after a taken branch.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic        zero,
    output logic [4:0]  dest_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] store_data,
    output logic        illegal,
    output logic        branch_taken,
    output logic [31:0] branch_target
);

    localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    dec_t               dec_p0;
    logic signed [31:0] imm_s_p0;
    logic        [31:0] opb_p0;
    logic        [31:0] target_p0;
    logic        [4:0]  dest_p0;
    logic               unused_instr_bits;

    logic               vld_p1;
    logic        [3:0]  alu_op_p1;
    logic        [31:0] alu_a_p1, alu_b_p1, store_data_p1, target_p1;
    logic        [4:0]  dest_p1;
    logic               reg_write_p1, mem_read_p1, mem_write_p1, illegal_p1;
    logic               is_beq_p1, is_bne_p1;

    logic               bt_p2;
    logic        [31:0] btgt_p2;
    logic [CNT_W-1:0]   flush_cnt;

    logic flushing, accept, fire, taken, discard, load;

    // rs/shamt fields are carried by rs_data and the funct decode respectively
    assign unused_instr_bits = ^{instr[25:21], instr[10:6]};

    alu_decode u_dec (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .dec    (dec_p0)
    );

    // ---- p0: decode and operand select (combinational from upstream beat)
    assign imm_s_p0  = sext16(instr[15:0]);
    assign target_p0 = pc + 32'd4 + {imm_s_p0[29:0], 2'b00};
    assign dest_p0   = dec_p0.dest_rd ? instr[15:11] : instr[20:16];

    always_comb begin
        case (dec_p0.imm_sel)
            IMM_SEXT: opb_p0 = imm_s_p0;
            IMM_ZEXT: opb_p0 = {16'h0000, instr[15:0]};
            default:  opb_p0 = rt_data;
        endcase
    end

    // zero feeds taken -> discard -> load combinationally within the consume cycle
    assign flushing = (flush_cnt != '0);
    assign in_ready = flushing || !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;
    assign fire     = vld_p1 && out_ready && (is_beq_p1 || is_bne_p1);
    assign taken    = fire && (is_beq_p1 ? zero : !zero);
    assign discard  = flushing || (taken && (FLUSH_CYCLES > 0));
    assign load     = accept && !discard;

    // ---- p1: ID/EX stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            flush_cnt <= '0;
            bt_p2     <= 1'b0;
            btgt_p2   <= '0;
        end else begin
            bt_p2 <= taken;
            if (taken)
                btgt_p2 <= target_p1;
            if (taken)
                flush_cnt <= (accept && (FLUSH_CYCLES > 0)) ? CNT_W'(FLUSH_CYCLES - 1)
                                                            : CNT_W'(FLUSH_CYCLES);
            else if (flushing && accept)
                flush_cnt <= flush_cnt - CNT_W'(1);
            if (load)
                vld_p1 <= 1'b1;
            else if (out_ready)
                vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_p1     <= '0;
            alu_a_p1      <= '0;
            alu_b_p1      <= '0;
            dest_p1       <= '0;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            illegal_p1    <= 1'b0;
            is_beq_p1     <= 1'b0;
            is_bne_p1     <= 1'b0;
            store_data_p1 <= '0;
            target_p1     <= '0;
        end else if (load) begin
            alu_op_p1     <= dec_p0.alu_op;
            alu_a_p1      <= rs_data;
            alu_b_p1      <= opb_p0;
            dest_p1       <= dest_p0;
            reg_write_p1  <= dec_p0.reg_write;
            mem_read_p1   <= dec_p0.mem_read;
            mem_write_p1  <= dec_p0.mem_write;
            illegal_p1    <= dec_p0.illegal;
            is_beq_p1     <= dec_p0.is_beq;
            is_bne_p1     <= dec_p0.is_bne;
            store_data_p1 <= dec_p0.mem_write ? rt_data : 32'h0;
            target_p1     <= target_p0;
        end
    end

    assign out_valid     = vld_p1;
    assign alu_op        = alu_op_p1;
    assign alu_a         = alu_a_p1;
    assign alu_b         = alu_b_p1;
    assign dest_reg      = dest_p1;
    assign reg_write     = reg_write_p1;
    assign mem_read      = mem_read_p1;
    assign mem_write     = mem_write_p1;
    assign store_data    = store_data_p1;
    assign illegal       = illegal_p1;
    assign branch_taken  = bt_p2;
    assign branch_target = btgt_p2;

endmodule
